// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory-access stage (master) and the
// data-memory responder (slave). Clock and reset travel as plain ports.
interface dmem_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ack_o;
    logic        mem_err_o;
    logic        mem_busy_o;

    modport master (
        output mem_ce_i,
        output mem_we_i,
        output mem_addr_i,
        output mem_sel_i,
        output mem_data_i,
        input  mem_data_o,
        input  mem_ack_o,
        input  mem_err_o,
        input  mem_busy_o
    );

    modport slave (
        input  mem_ce_i,
        input  mem_we_i,
        input  mem_addr_i,
        input  mem_sel_i,
        input  mem_data_i,
        output mem_data_o,
        output mem_ack_o,
        output mem_err_o,
        output mem_busy_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory slave for the memory-access stage: word-organised single-port
// RAM with byte-lane stores, programmable wait states and a req/ack handshake.
// A request is latched in IDLE, waits WAIT_CYCLES edges, is performed on the
// access edge and acknowledged for exactly one cycle in RESP.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // Copies of the request taken at acceptance; the bus inputs are ignored
    // for the rest of the transaction.
    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdata_q;

    logic [31:0]   ram [DEPTH];

    logic [AW-1:0] word_idx;
    logic          addr_err;
    logic          access;
    logic          ram_we;
    logic          accept;

    assign accept   = (state == IDLE) && bus.mem_ce_i;
    assign word_idx = addr_q[AW+1:2];
    // Out of range words and misaligned byte addresses are both rejected.
    assign addr_err = ({2'b00, addr_q[31:2]} >= 32'(DEPTH)) || (addr_q[1:0] != 2'b00);
    assign access   = (state == WAIT) && (wait_cnt == '0);
    // Because state drops to IDLE asynchronously, a reset inside WAIT can
    // never let a pending store reach the RAM.
    assign ram_we   = access && we_q && !addr_err;

    assign bus.mem_busy_o = (state != IDLE);

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.mem_we_i;
            addr_q  <= bus.mem_addr_i;
            sel_q   <= bus.mem_sel_i;
            wdata_q <= bus.mem_data_i;
        end
    end

    // Byte-lane store into the RAM on the access edge; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    ram[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered load data, ack and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            bus.mem_data_o <= '0;
            bus.mem_ack_o  <= 1'b0;
            bus.mem_err_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_ce_i) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        bus.mem_ack_o <= 1'b1;
                        state         <= RESP;
                        if (addr_err) begin
                            bus.mem_err_o  <= 1'b1;
                            bus.mem_data_o <= '0;
                        end else if (!we_q) begin
                            bus.mem_data_o <= ram[word_idx];
                        end
                    end
                end
                RESP: begin
                    bus.mem_ack_o <= 1'b0;
                    bus.mem_err_o <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.mem_ack_o <= 1'b0;
                    bus.mem_err_o <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// DEPTH=1024, a second with no wait states for the back-to-back pattern.
module tb_dmem_responder;

    localparam int DEPTH0 = 1024;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dmem_if if0 ();
    dmem_if if1 ();

    dmem_responder #(.DEPTH(DEPTH0), .WAIT_CYCLES(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request into dut0 and follows it to completion. lat is the
    // number of edges from acceptance to the edge that raises ack; busy_cnt
    // counts sampled busy cycles; ack_after is ack one cycle after the pulse.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wdata, input bit scramble,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int busy_cnt, output logic ack_after);
        bit done;
        done      = 1'b0;
        lat       = -1;
        busy_cnt  = 0;
        rdata     = '0;
        err       = 1'b0;
        ack_after = 1'b0;
        @(negedge clk);
        if0.mem_ce_i   = 1'b1;
        if0.mem_we_i   = we;
        if0.mem_addr_i = addr;
        if0.mem_sel_i  = sel;
        if0.mem_data_i = wdata;
        for (int n = 1; n <= 20 && !done; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                if0.mem_ce_i = 1'b0;
                if (scramble) begin
                    if0.mem_we_i   = ~we;
                    if0.mem_addr_i = ~addr;
                    if0.mem_sel_i  = ~sel;
                    if0.mem_data_i = ~wdata;
                end
            end
            if (if0.mem_busy_o) busy_cnt++;
            if (if0.mem_ack_o) begin
                done  = 1'b1;
                lat   = n - 1;
                rdata = if0.mem_data_o;
                err   = if0.mem_err_o;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout addr=%h got no ack, required ack within 20 cycles", addr);
        end else begin
            @(posedge clk);
            @(negedge clk);
            ack_after = if0.mem_ack_o;
            if (if0.mem_busy_o) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({if0.mem_data_o, if0.mem_ack_o, if0.mem_err_o, if0.mem_busy_o} !== 35'd0) begin
            failures++;
            $display("FAIL reset_dut0 got data=%h ack=%b err=%b busy=%b required all 0",
                     if0.mem_data_o, if0.mem_ack_o, if0.mem_err_o, if0.mem_busy_o);
        end
        checks++;
        if ({if1.mem_data_o, if1.mem_ack_o, if1.mem_err_o, if1.mem_busy_o} !== 35'd0) begin
            failures++;
            $display("FAIL reset_dut1 got data=%h ack=%b err=%b busy=%b required all 0",
                     if1.mem_data_o, if1.mem_ack_o, if1.mem_err_o, if1.mem_busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_latency();
        logic [31:0] rd;
        logic        er, aa;
        int          lat, bc;
        run_txn(1'b1, 32'(4 * (DEPTH0 - 1)), 4'hF, 32'hA5A5A5A5, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b0, 32'(4 * (DEPTH0 - 1)), 4'h0, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL last_word_data got=%h required=%h", rd, 32'hA5A5A5A5);
        end
        checks++;
        if (er !== 1'b0) begin
            failures++;
            $display("FAIL last_word_err got=%b required=0", er);
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL ack_latency got=%0d required=3", lat);
        end
        checks++;
        if (bc != 4) begin
            failures++;
            $display("FAIL busy_cycles got=%0d required=4", bc);
        end
        checks++;
        if (aa !== 1'b0) begin
            failures++;
            $display("FAIL ack_width got ack=%b one cycle later, required 0", aa);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er, aa;
        int          lat, bc;
        run_txn(1'b1, 32'h10, 4'hF, 32'h11223344, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b1, 32'h10, 4'b0101, 32'hFFFFFFFF, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'h11FF33FF) begin
            failures++;
            $display("FAIL lane_merge got=%h required=%h", rd, 32'h11FF33FF);
        end
        // Empty lane mask: acks, writes nothing, and the last load value is held.
        run_txn(1'b1, 32'h10, 4'h0, 32'h00000000, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'h11FF33FF || er !== 1'b0) begin
            failures++;
            $display("FAIL sel0_store_hold got data=%h err=%b required data=%h err=0", rd, er, 32'h11FF33FF);
        end
        run_txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'h11FF33FF) begin
            failures++;
            $display("FAIL sel0_no_write got=%h required=%h", rd, 32'h11FF33FF);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er, aa;
        int          lat, bc;
        run_txn(1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b0, 32'h1002, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL misaligned_load got err=%b data=%h required err=1 data=0", er, rd);
        end
        checks++;
        if (aa !== 1'b0) begin
            failures++;
            $display("FAIL err_clears got ack=%b after pulse, required 0", aa);
        end
        run_txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b0, 32'(4 * DEPTH0), 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL range_load got err=%b data=%h required err=1 data=0", er, rd);
        end
        run_txn(1'b0, 32'(4 * (DEPTH0 - 1)), 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b1, 32'(4 * DEPTH0), 4'hF, 32'hCAFEBABE, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL range_store got err=%b data=%h required err=1 data=0", er, rd);
        end
        run_txn(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            failures++;
            $display("FAIL range_store_no_write got data=%h err=%b required data=%h err=0", rd, er, 32'h0BADF00D);
        end
        run_txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'h11FF33FF) begin
            failures++;
            $display("FAIL err_ram_intact got=%h required=%h", rd, 32'h11FF33FF);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd;
        logic        er, aa;
        int          lat, bc;
        int          acks;
        run_txn(1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, rd, er, lat, bc, aa);
        run_txn(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        @(negedge clk);
        if0.mem_ce_i   = 1'b1;
        if0.mem_we_i   = 1'b1;
        if0.mem_addr_i = 32'h20;
        if0.mem_sel_i  = 4'hF;
        if0.mem_data_i = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        if0.mem_ce_i = 1'b0;
        checks++;
        if (if0.mem_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL store_accepted got busy=%b required 1", if0.mem_busy_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({if0.mem_data_o, if0.mem_ack_o, if0.mem_err_o, if0.mem_busy_o} !== 35'd0) begin
            failures++;
            $display("FAIL async_reset got data=%h ack=%b err=%b busy=%b required all 0",
                     if0.mem_data_o, if0.mem_ack_o, if0.mem_err_o, if0.mem_busy_o);
        end
        @(negedge clk);
        rst  = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (if0.mem_ack_o) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL aborted_no_ack got acks=%0d required 0", acks);
        end
        run_txn(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'h12345678) begin
            failures++;
            $display("FAIL aborted_no_write got=%h required=%h", rd, 32'h12345678);
        end
    endtask

    task automatic test_latched_inputs();
        logic [31:0] rd;
        logic        er, aa;
        int          lat, bc;
        run_txn(1'b1, 32'h30, 4'hF, 32'h55AA55AA, 1'b1, rd, er, lat, bc, aa);
        checks++;
        if (er !== 1'b0) begin
            failures++;
            $display("FAIL latched_store_err got=%b required=0", er);
        end
        run_txn(1'b0, 32'h30, 4'hF, 32'h0, 1'b1, rd, er, lat, bc, aa);
        checks++;
        if (rd !== 32'h55AA55AA || er !== 1'b0) begin
            failures++;
            $display("FAIL latched_load got data=%h err=%b required data=%h err=0", rd, er, 32'h55AA55AA);
        end
    endtask

    task automatic test_back_to_back();
        int  acks;
        bit  exp_ack, exp_busy;
        @(negedge clk);
        if1.mem_ce_i   = 1'b1;
        if1.mem_we_i   = 1'b1;
        if1.mem_addr_i = 32'h4;
        if1.mem_sel_i  = 4'hF;
        if1.mem_data_i = 32'h01020304;
        acks = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ack  = (k % 3 == 2);
            exp_busy = (k % 3 != 0);
            if (if1.mem_ack_o) acks++;
            checks++;
            if (if1.mem_ack_o !== exp_ack || if1.mem_busy_o !== exp_busy) begin
                failures++;
                $display("FAIL b2b_cycle%0d got ack=%b busy=%b required ack=%b busy=%b",
                         k, if1.mem_ack_o, if1.mem_busy_o, exp_ack, exp_busy);
            end
        end
        if1.mem_ce_i = 1'b0;
        checks++;
        if (acks != 4) begin
            failures++;
            $display("FAIL b2b_ack_count got=%0d required=4", acks);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        if0.mem_ce_i   = 1'b0;
        if0.mem_we_i   = 1'b0;
        if0.mem_addr_i = '0;
        if0.mem_sel_i  = '0;
        if0.mem_data_i = '0;
        if1.mem_ce_i   = 1'b0;
        if1.mem_we_i   = 1'b0;
        if1.mem_addr_i = '0;
        if1.mem_sel_i  = '0;
        if1.mem_data_i = '0;
        test_reset();
        test_read_latency();
        test_byte_lanes();
        test_errors();
        test_reset_mid_store();
        test_latched_inputs();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
